// File: rtl/sync_modn_down_counter.sv
// Mod-N down counter with range-checked parallel load, registered
// terminal-count pulse and a saturating wrap tally.
module sync_modn_down_counter #(
    parameter int unsigned N = 10,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] count,
    output logic         tc,
    output logic         load_err,
    output logic [7:0]   wraps
);

    localparam int unsigned WRAPS_W = 8;

    // N may equal 2^W, so the load range check is done one bit wider.
    localparam logic [W:0]         N_EXT     = (W+1)'(N);
    localparam logic [W-1:0]       COUNT_MAX = W'(N - 1);
    localparam logic [WRAPS_W-1:0] WRAPS_SAT = '1;

    logic din_ok;
    assign din_ok = ({1'b0, din} < N_EXT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= COUNT_MAX;
            tc       <= 1'b0;
            load_err <= 1'b0;
            wraps    <= '0;
        end else if (load) begin
            count    <= din_ok ? din : COUNT_MAX;
            load_err <= !din_ok;
            tc       <= 1'b0;
        end else if (en) begin
            load_err <= 1'b0;
            if (count == '0) begin
                count <= COUNT_MAX;
                tc    <= 1'b1;
                if (wraps != WRAPS_SAT) begin
                    wraps <= wraps + WRAPS_W'(1);
                end
            end else begin
                count <= count - W'(1);
                tc    <= 1'b0;
            end
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_modn_down_counter.sv
// Bench for sync_modn_down_counter: an N=10 and an N=1 instance, each tracked
// by an arithmetic reference model, with directed steps then random stimulus.
module tb_sync_modn_down_counter;

    typedef struct {
        int count;
        int tc;
        int err;
        int wraps;
    } st_t;

    logic       clk = 1'b0;
    logic       a_rst, a_en, a_load;
    logic [3:0] a_din;
    logic [3:0] a_count;
    logic       a_tc, a_err;
    logic [7:0] a_wraps;
    logic       b_rst, b_en, b_load;
    logic [0:0] b_din;
    logic [0:0] b_count;
    logic       b_tc, b_err;
    logic [7:0] b_wraps;

    int compared = 0;
    int mismatched = 0;
    st_t ma, mb;

    always #5 clk = ~clk;

    sync_modn_down_counter #(.N(10), .W(4)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .load(a_load), .din(a_din),
        .count(a_count), .tc(a_tc), .load_err(a_err), .wraps(a_wraps)
    );

    sync_modn_down_counter #(.N(1), .W(1)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .load(b_load), .din(b_din),
        .count(b_count), .tc(b_tc), .load_err(b_err), .wraps(b_wraps)
    );

    function automatic st_t model(st_t s, int n, bit rst, bit load, bit en, int din);
        st_t r = s;
        if (!rst) begin
            r.count = n - 1; r.tc = 0; r.err = 0; r.wraps = 0;
        end else if (load) begin
            r.count = (din < n) ? din : n - 1;
            r.err   = (din < n) ? 0 : 1;
            r.tc    = 0;
        end else if (en) begin
            r.err = 0;
            if (s.count == 0) begin
                r.count = n - 1;
                r.tc    = 1;
                r.wraps = (s.wraps < 255) ? s.wraps + 1 : 255;
            end else begin
                r.count = s.count - 1;
                r.tc    = 0;
            end
        end else begin
            r.tc = 0; r.err = 0;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge: both models advance, both DUTs compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        ma = model(ma, 10, a_rst, a_load, a_en, int'(a_din));
        mb = model(mb, 1, b_rst, b_load, b_en, int'(b_din));
        #1;
        check("a.count", 32'(a_count), ma.count);
        check("a.tc",    32'(a_tc),    ma.tc);
        check("a.err",   32'(a_err),   ma.err);
        check("a.wraps", 32'(a_wraps), ma.wraps);
        check("b.count", 32'(b_count), mb.count);
        check("b.tc",    32'(b_tc),    mb.tc);
        check("b.err",   32'(b_err),   mb.err);
        check("b.wraps", 32'(b_wraps), mb.wraps);
    endtask

    task automatic set_a(input logic rst, input logic load, input logic en, input logic [3:0] din);
        a_rst = rst; a_load = load; a_en = en; a_din = din;
    endtask

    task automatic set_b(input logic rst, input logic load, input logic en, input logic [0:0] din);
        b_rst = rst; b_load = load; b_en = en; b_din = din;
    endtask

    initial begin
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        set_b(1'b0, 1'b1, 1'b1, 1'b1);

        // Reset overrides load and en
        set_a(1'b0, 1'b1, 1'b1, 4'd3);
        step();
        step();
        check("rst.count", 32'(a_count), 9);
        check("rst.wraps", 32'(a_wraps), 0);

        // Full countdown to one wrap, then two more
        set_a(1'b1, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 10; i++) step();
        check("wrap1.count", 32'(a_count), 9);
        check("wrap1.tc",    32'(a_tc),    1);
        check("wrap1.wraps", 32'(a_wraps), 1);
        for (int i = 0; i < 20; i++) step();
        check("wrap3.wraps", 32'(a_wraps), 3);

        // Enable gating from count=5
        set_a(1'b1, 1'b1, 1'b0, 4'd5);
        step();
        set_a(1'b1, 1'b0, 1'b1, 4'd0); step();
        set_a(1'b1, 1'b0, 1'b0, 4'd0); step(); step();
        set_a(1'b1, 1'b0, 1'b1, 4'd0); step();
        check("gate.count", 32'(a_count), 3);

        // Load rules
        set_a(1'b1, 1'b1, 1'b1, 4'd2); step();
        check("ld2.count", 32'(a_count), 2);
        set_a(1'b1, 1'b1, 1'b0, 4'd12); step();
        check("ld12.count", 32'(a_count), 9);
        check("ld12.err",   32'(a_err),   1);
        set_a(1'b1, 1'b0, 1'b0, 4'd0); step();
        check("ld12.err_clr", 32'(a_err), 0);
        set_a(1'b1, 1'b1, 1'b0, 4'd0); step();
        set_a(1'b1, 1'b1, 1'b1, 4'd7); step();
        check("ld_at0.count", 32'(a_count), 7);
        check("ld_at0.tc",    32'(a_tc),    0);
        check("ld_at0.wraps", 32'(a_wraps), 3);

        // Saturation at 255 wraps, then reset mid-count
        set_a(1'b1, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 2600; i++) step();
        check("sat.wraps", 32'(a_wraps), 255);
        set_a(1'b1, 1'b1, 1'b0, 4'd4); step();
        set_a(1'b0, 1'b0, 1'b1, 4'd0); step();
        check("midrst.count", 32'(a_count), 9);
        check("midrst.wraps", 32'(a_wraps), 0);
        check("midrst.tc",    32'(a_tc),    0);

        // N=1 instance: continuous tc, out-of-range load
        set_a(1'b1, 1'b0, 1'b0, 4'd0);
        set_b(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("n1.tc", 32'(b_tc), 1);
        end
        check("n1.count", 32'(b_count), 0);
        check("n1.wraps", 32'(b_wraps), 5);
        set_b(1'b1, 1'b1, 1'b1, 1'b1); step();
        check("n1.ld.count", 32'(b_count), 0);
        check("n1.ld.err",   32'(b_err),   1);

        // Random stimulus against the models
        for (int i = 0; i < 600; i++) begin
            set_a(1'($urandom_range(0, 24) != 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
            set_b(1'($urandom_range(0, 24) != 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
